// File: rtl/gray_counter.sv
// gray_counter
//
// Up/down binary counter that presents its count as binary and as reflected
// Gray code through a valid/ready stream. A word is offered only in RUN, and
// the count advances by one on each accepted transfer. A preset can be
// loaded while IDLE. A one-cycle wrap pulse follows every transfer that
// rolls the count over.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      leave IDLE and begin offering words (ignored in RUN)
//   stop       return to IDLE at the next edge (ignored in IDLE)
//   up         direction used by the next advance: 1 = +1, 0 = -1
//   load       preset strobe, honoured in IDLE only
//   load_bin   binary preset value
//   out_valid  a code word is offered on gray/bin
//   out_ready  consumer accepts the offered word
//   gray       registered Gray code of bin
//   bin        registered binary count
//   out_last   next advance in the current direction wraps (combinational)
//   wrap       high for the cycle after a wrapping transfer
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             out_last,
  output logic             wrap
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Modulo 2^WIDTH step. Wrap-around comes from the fixed result width.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] b,
                                               input logic             inc);
    return inc ? (b + ONE) : (b - ONE);
  endfunction

  logic [0:0]       state_p1;
  logic [WIDTH-1:0] bin_p1;
  logic [WIDTH-1:0] gray_p1;
  logic             wrap_p1;

  logic             xfer_p0;
  logic             last_p0;
  logic [WIDTH-1:0] bin_nxt_p0;

  // Stage p0: decode this cycle's handshake and the advanced count.
  assign last_p0    = (up && (bin_p1 == ALL_ONES)) || (!up && (bin_p1 == '0));
  assign xfer_p0    = (state_p1 == RUN) && out_ready;
  assign bin_nxt_p0 = advance(bin_p1, up);

  // Stage p1: registered state, count, code and wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      bin_p1   <= '0;
      gray_p1  <= '0;
      wrap_p1  <= 1'b0;
    end else begin
      wrap_p1 <= xfer_p0 && last_p0;
      case (state_p1)
        IDLE: begin
          // load and start may coincide; RUN then opens on the preset.
          if (load) begin
            bin_p1  <= load_bin;
            gray_p1 <= bin_to_gray(load_bin);
          end
          if (start) begin
            state_p1 <= RUN;
          end
        end
        default: begin
          // A transfer in the same cycle as stop still completes.
          if (xfer_p0) begin
            bin_p1  <= bin_nxt_p0;
            gray_p1 <= bin_to_gray(bin_nxt_p0);
          end
          if (stop) begin
            state_p1 <= IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid = (state_p1 == RUN);
  assign bin       = bin_p1;
  assign gray      = gray_p1;
  assign wrap      = wrap_p1;
  assign out_last  = last_p0;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] gray;
  logic [W-1:0] bin;
  logic         out_last;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: running flag, integer count, pending wrap pulse.
  bit m_run = 1'b0;
  int m_bin = 0;
  bit m_wrap = 1'b0;

  gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .up(up),
    .load(load), .load_bin(load_bin), .out_valid(out_valid),
    .out_ready(out_ready), .gray(gray), .bin(bin), .out_last(out_last),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic check_all(input string tag);
    int lastv;
    lastv = (up && m_bin == MOD - 1) || (!up && m_bin == 0) ? 1 : 0;
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, m_run});
    chk({tag, ".bin"},   {28'b0, bin},  m_bin);
    chk({tag, ".gray"},  {28'b0, gray}, gray_of(m_bin));
    chk({tag, ".wrap"},  {31'b0, wrap}, {31'b0, m_wrap});
    chk({tag, ".last"},  {31'b0, out_last}, lastv);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check.
  task automatic step(input string tag, input logic st, input logic sp,
                      input logic u, input logic ld, input logic [W-1:0] lb,
                      input logic rdy);
    bit xfer;
    bit nrun;
    int nbin;
    logic [W-1:0] g_before;
    start = st; stop = sp; up = u; load = ld; load_bin = lb; out_ready = rdy;
    g_before = gray;
    xfer = m_run && rdy;
    nrun = m_run;
    nbin = m_bin;
    if (!m_run) begin
      if (ld) nbin = int'(lb);
      if (st) nrun = 1'b1;
    end else begin
      if (xfer) nbin = u ? (m_bin + 1) % MOD : (m_bin + MOD - 1) % MOD;
      if (sp) nrun = 1'b0;
    end
    @(posedge clk);
    m_wrap = xfer && (u ? (m_bin == MOD - 1) : (m_bin == 0));
    m_run = nrun;
    m_bin = nbin;
    #1;
    check_all(tag);
    if (xfer) chk({tag, ".onebit"}, $countones(g_before ^ gray), 1);
  endtask

  // Assert reset between edges and check outputs before any clock arrives.
  task automatic reset_mid(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, ".valid"}, {31'b0, out_valid}, 0);
    chk({tag, ".bin"},   {28'b0, bin}, 0);
    chk({tag, ".gray"},  {28'b0, gray}, 0);
    chk({tag, ".wrap"},  {31'b0, wrap}, 0);
    m_run = 1'b0; m_bin = 0; m_wrap = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [W-1:0] up_seq [17];

  initial begin
    up_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // Reset state
    #12;
    chk("rst.valid", {31'b0, out_valid}, 0);
    chk("rst.bin", {28'b0, bin}, 0);
    chk("rst.gray", {28'b0, gray}, 0);
    chk("rst.wrap", {31'b0, wrap}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Up sweep through a full cycle and back to zero
    step("start", 1, 0, 1, 0, '0, 1);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("sweep%0d.gray", i), {28'b0, gray}, {28'b0, up_seq[i]});
      chk($sformatf("sweep%0d.last", i), {31'b0, out_last}, (i == 15) ? 1 : 0);
      step("sweep", 0, 0, 1, 0, '0, 1);
      if (i == 15) chk("sweep.wrapzero", {31'b0, wrap}, 1);
      if (i == 16) chk("sweep.wrapgone", {31'b0, wrap}, 0);
    end
    step("halt1", 0, 1, 1, 0, '0, 0);

    // Down wrap from a preset of zero
    step("dload", 1, 0, 0, 1, 4'h0, 0);
    chk("down.first", {27'b0, out_last, bin}, {27'b0, 1'b1, 4'h0});
    step("down1", 0, 0, 0, 0, '0, 1);
    chk("down.F", {23'b0, wrap, gray, bin}, {23'b0, 1'b1, 4'h8, 4'hF});
    step("down2", 0, 0, 0, 0, '0, 1);
    chk("down.E", {24'b0, gray, bin}, {24'b0, 4'h9, 4'hE});
    step("halt2", 0, 1, 0, 0, '0, 0);

    // Backpressure holds the offered word
    step("bload", 1, 0, 1, 1, 4'h3, 0);
    for (int i = 0; i < 3; i++) begin
      step("bp", 0, 0, 1, 0, '0, 0);
      chk("bp.hold", {27'b0, out_valid, gray}, {27'b0, 1'b1, 4'h2});
    end
    step("bp.go", 0, 0, 1, 0, '0, 1);
    chk("bp.next", {24'b0, gray, bin}, {24'b0, 4'h6, 4'h4});
    step("halt3", 0, 1, 1, 0, '0, 0);

    // Load rules
    step("ld5", 0, 0, 1, 1, 4'h5, 0);
    chk("ld5.val", {24'b0, gray, bin}, {24'b0, 4'h7, 4'h5});
    step("ld.start", 1, 0, 1, 0, '0, 0);
    step("ld.run1", 0, 0, 1, 1, 4'hA, 1);
    chk("ld.ignored1", {28'b0, bin}, {28'b0, 4'h6});
    step("ld.run2", 0, 0, 1, 1, 4'hA, 0);
    chk("ld.ignored2", {28'b0, bin}, {28'b0, 4'h6});

    // Stop together with a transfer
    step("stopx", 0, 1, 1, 0, '0, 1);
    chk("stopx.res", {23'b0, out_valid, gray, bin}, {23'b0, 1'b0, 4'h4, 4'h7});
    step("resume", 1, 0, 1, 0, '0, 0);
    chk("resume.bin", {27'b0, out_valid, bin}, {27'b0, 1'b1, 4'h7});

    // Reset mid-stream at bin = 9
    step("to8", 0, 0, 1, 0, '0, 1);
    step("to9", 0, 0, 1, 0, '0, 1);
    chk("pre.rst", {28'b0, bin}, 9);
    reset_mid("rstmid");
    for (int i = 0; i < 3; i++) begin
      step("postrst", 0, 0, 1, 0, '0, 1);
      chk("postrst.idle", {31'b0, out_valid}, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic st, sp, u, ld, rdy;
      logic [W-1:0] lb;
      st  = ($urandom_range(3) == 0);
      sp  = ($urandom_range(15) == 0);
      u   = $urandom_range(1);
      ld  = ($urandom_range(3) == 0);
      lb  = W'($urandom);
      rdy = ($urandom_range(3) != 0);
      step("rnd", st, sp, u, ld, lb, rdy);
      if ($urandom_range(99) == 0) reset_mid("rndrst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Sequential Gray-code source: a WIDTH-bit up/down counter that holds a binary count and presents it as both binary and reflected Gray code. Results go out through a valid/ready stream with backpressure, so downstream Gray-to-binary decoders and lab test fixtures can consume one code word per accepted transfer. The counter also gives a preset load, start/stop control and a wrap indication. It is the stimulus and producer side of the team's Gray conversion blocks.

## Interface
- WIDTH, 4, counter and code width in bits (legal range 2..16)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to leave IDLE and begin streaming
- stop  input  1  request to return to IDLE
- up  input  1  count direction on the next advance: 1 = increment, 0 = decrement
- load  input  1  preset strobe, honoured in IDLE only
- load_bin  input  WIDTH  binary preset value
- out_valid  output  1  code word on gray/bin is offered
- out_ready  input  1  consumer accepts the offered word
- gray  output  WIDTH  registered Gray code of bin, gray = bin ^ (bin >> 1)
- bin  output  WIDTH  registered binary count
- out_last  output  1  the next advance in the current direction will wrap (combinational from bin and up)
- wrap  output  1  one-cycle pulse: the count just wrapped

## Operation
- State machine with two states, IDLE and RUN.
- Reset (rst_n low, any time, asynchronous):
  - state = IDLE; bin = 0; gray = 0; out_valid = 0; wrap = 0.
  - Any in-flight offer is discarded; there is no partial-transfer recovery.
- IDLE:
  - out_valid = 0.
  - load = 1 sets bin <= load_bin and gray <= load_bin ^ (load_bin >> 1).
  - start = 1 moves to RUN. If load and start are high in the same cycle, both take effect: RUN begins with the loaded value.
  - stop is ignored in IDLE.
- RUN:
  - out_valid = 1.
  - A transfer is out_valid & out_ready at a rising edge.
  - On a transfer, bin advances by +1 (up = 1) or -1 (up = 0), modulo 2^WIDTH; gray follows.
  - Without a transfer, bin, gray and out_valid hold.
  - load and start are ignored in RUN.
- stop in RUN: the state becomes IDLE at the next edge. A transfer in the same cycle still completes and advances the count.
- Wrap conditions:
  - up = 1 and bin = 2^WIDTH-1 at a transfer, giving bin = 0.
  - up = 0 and bin = 0 at a transfer, giving bin = 2^WIDTH-1.
  - In either case wrap = 1 for exactly the cycle after that edge.
- out_last = (up & bin == all-ones) | (~up & bin == 0). It is valid in every state.
- Gray property: consecutive accepted words differ in exactly one bit, including across a wrap and across a direction change.

## Timing
- start sampled at edge N: out_valid = 1 from cycle N+1, showing the current (or loaded) value.
- Transfer at edge k: the new bin/gray is visible in cycle k+1. Throughput is one word per cycle while out_ready stays high.
- up is sampled at the transfer edge only; changing it between transfers costs no bubble.
- stop sampled at edge M: out_valid = 0 from cycle M+1.
- wrap is registered and high only in cycle k+1 after a wrapping transfer at edge k.
- The offered word is stable while out_valid = 1 and out_ready = 0.
- Reset deassertion is synchronised by the integrator. The first active edge after release is treated as a normal IDLE cycle.

## Test plan
- Up sweep, WIDTH = 4:
  - Stimulus: reset, start, out_ready held high for 17 transfers.
  - Required gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - Required: wrap high for exactly one cycle when 0 reappears; out_last high while bin = F.
- Down wrap:
  - Stimulus: load_bin = 0, up = 0, start.
  - Required first word bin = 0, gray = 0, out_last = 1.
  - Required next word bin = F, gray = 8, with a wrap pulse, then bin = E, gray = 9.
- Backpressure:
  - Stimulus: in RUN at bin = 3, drop out_ready for 3 cycles.
  - Required: out_valid = 1 and gray = 2 held for all 3 cycles.
  - Required: after raising out_ready, the next word is bin = 4, gray = 6.
- Load rules:
  - Stimulus: load_bin = 5 with load in IDLE.
  - Required: bin = 5, gray = 7 next cycle.
  - Stimulus: load_bin = A with load during RUN.
  - Required: ignored; bin is unchanged apart from normal advances.
- Stop with transfer:
  - Stimulus: in RUN at bin = 6, assert stop and out_ready in the same cycle.
  - Required: bin = 7, gray = 4, out_valid = 0 in the next cycle; then start resumes at 7.
- Reset mid-stream:
  - Stimulus: pull rst_n low between clock edges in RUN at bin = 9.
  - Required immediately: out_valid = 0, bin = 0, gray = 0, wrap = 0.
  - Required after release: stays IDLE until start.
